// File: rtl/interrupt_controller.sv
// Eight-source interrupt controller feeding the CPU control unit.
// It latches rising edges into a pending register and applies a software enable mask.
// The lowest eligible index wins. The request is held frozen until the CPU's
// handler-return acknowledge. Mask, pending and status are exposed on a 4-entry
// config port.
module interrupt_controller #(
    parameter logic [7:0] MASK_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq_in,
    output logic        interrupt_en,
    output logic [2:0]  interrupt_num,
    input  logic        interrupt_ack,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_data_in,
    input  logic        cfg_read_en,
    input  logic        cfg_write_en,
    output logic [15:0] cfg_data_out
);

    typedef enum logic [1:0] {StIdle, StRequest, StAckWait} state_e;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [2:0]  num_q, num_d;
    logic [7:0]  irq_prev_q, irq_prev_d;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] dout_q, dout_d;

    logic [7:0]  set_vec;
    logic [7:0]  clr_ack;
    logic [7:0]  clr_sw;
    logic [7:0]  eligible;
    logic [2:0]  winner;
    logic [15:0] rd_data;

    // Only the low byte of write data maps onto any register.
    logic unused_wdata;
    assign unused_wdata = ^cfg_data_in[15:8];

    // Edge detect and pending update; a new edge beats any clear on the same cycle.
    always_comb begin
        set_vec    = irq_in & ~irq_prev_q;
        irq_prev_d = irq_in;
        clr_ack    = 8'h00;
        if (state_q == StRequest && interrupt_ack) begin
            clr_ack = 8'h01 << num_q;
        end
        clr_sw = 8'h00;
        if (cfg_write_en && cfg_addr == 2'd1) begin
            clr_sw = cfg_data_in[7:0];
        end
        pending_d = (pending_q & ~(clr_ack | clr_sw)) | set_vec;
        mask_d    = mask_q;
        if (cfg_write_en && cfg_addr == 2'd0) begin
            mask_d = cfg_data_in[7:0];
        end
    end

    // Lowest set index among the enabled pending sources.
    always_comb begin
        eligible = pending_q & mask_q;
        winner   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // Request FSM next state; en/num only change on IDLE->REQUEST and REQUEST->ACK_WAIT.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        num_d   = num_q;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StRequest;
                    en_d    = 1'b1;
                    num_d   = winner;
                end
            end
            StRequest: begin
                if (interrupt_ack) begin
                    state_d = StAckWait;
                    en_d    = 1'b0;
                end
            end
            StAckWait: begin
                en_d = 1'b0;
                if (!interrupt_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                en_d    = 1'b0;
            end
        endcase
    end

    // Config read mux from current register values, so a same-cycle write reads old data.
    always_comb begin
        rd_data = 16'h0000;
        unique case (cfg_addr)
            2'd0: rd_data = {8'h00, mask_q};
            2'd1: rd_data = {8'h00, pending_q};
            2'd2: rd_data = {11'h000, num_q, (state_q == StAckWait), en_q};
            2'd3: rd_data = 16'h0000;
            default: rd_data = 16'h0000;
        endcase
        dout_d = cfg_read_en ? rd_data : dout_q;
    end

    // All state, with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            en_q       <= 1'b0;
            num_q      <= 3'd0;
            irq_prev_q <= 8'h00;
            pending_q  <= 8'h00;
            mask_q     <= MASK_RESET;
            dout_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            num_q      <= num_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            dout_q     <= dout_d;
        end
    end

    assign interrupt_en  = en_q;
    assign interrupt_num = num_q;
    assign cfg_data_out  = dout_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed, table-driven bench for interrupt_controller: one row per clock,
// plus hand-written sequences for asynchronous reset and reset-edge behaviour.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        interrupt_en;
    logic [2:0]  interrupt_num;
    logic        interrupt_ack;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data_in;
    logic        cfg_read_en;
    logic        cfg_write_en;
    logic [15:0] cfg_data_out;

    int total = 0;
    int bad   = 0;

    interrupt_controller dut (
        .clk           (clk),
        .rst           (rst),
        .irq_in        (irq_in),
        .interrupt_en  (interrupt_en),
        .interrupt_num (interrupt_num),
        .interrupt_ack (interrupt_ack),
        .cfg_addr      (cfg_addr),
        .cfg_data_in   (cfg_data_in),
        .cfg_read_en   (cfg_read_en),
        .cfg_write_en  (cfg_write_en),
        .cfg_data_out  (cfg_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  irq;
        logic        ack;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        rd;
        logic        wr;
        logic        en;
        logic [2:0]  num;
        logic [15:0] dout;
    } vec_t;

    localparam int NV = 43;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [7:0] irq, input logic ack, input logic [1:0] addr,
                                input logic [15:0] wdata, input logic rd, input logic wr,
                                input logic en, input logic [2:0] num, input logic [15:0] dout);
        vec_t v;
        v.irq = irq; v.ack = ack; v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr;
        v.en = en; v.num = num; v.dout = dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] irq, input logic ack, input logic [1:0] addr,
                         input logic [15:0] wdata, input logic rd, input logic wr);
        irq_in        = irq;
        interrupt_ack = ack;
        cfg_addr      = addr;
        cfg_data_in   = wdata;
        cfg_read_en   = rd;
        cfg_write_en  = wr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // irq ack addr wdata rd wr | en num dout
        // Basic flow
        vecs[0]  = mk(8'h00, 0, 2'd0, 16'h0008, 0, 1, 0, 3'd0, 16'h0000);
        vecs[1]  = mk(8'h08, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000);
        vecs[2]  = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd3, 16'h0000);
        vecs[3]  = mk(8'h00, 1, 2'd0, 16'h0000, 0, 0, 0, 3'd3, 16'h0000);
        vecs[4]  = mk(8'h00, 1, 2'd2, 16'h0000, 1, 0, 0, 3'd3, 16'h000E);
        vecs[5]  = mk(8'h00, 1, 2'd1, 16'h0000, 1, 0, 0, 3'd3, 16'h0000);
        vecs[6]  = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd3, 16'h0000);
        vecs[7]  = mk(8'h00, 0, 2'd2, 16'h0000, 1, 0, 0, 3'd3, 16'h000C);
        // Priority
        vecs[8]  = mk(8'h00, 0, 2'd0, 16'h00FF, 0, 1, 0, 3'd3, 16'h000C);
        vecs[9]  = mk(8'h24, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd3, 16'h000C);
        vecs[10] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd2, 16'h000C);
        vecs[11] = mk(8'h00, 1, 2'd0, 16'h0000, 0, 0, 0, 3'd2, 16'h000C);
        vecs[12] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd2, 16'h000C);
        vecs[13] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd5, 16'h000C);
        // Freeze
        vecs[14] = mk(8'h01, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd5, 16'h000C);
        vecs[15] = mk(8'h00, 0, 2'd1, 16'h0000, 1, 0, 1, 3'd5, 16'h0021);
        vecs[16] = mk(8'h00, 1, 2'd0, 16'h0000, 0, 0, 0, 3'd5, 16'h0021);
        vecs[17] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd5, 16'h0021);
        vecs[18] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd0, 16'h0021);
        vecs[19] = mk(8'h00, 1, 2'd0, 16'h0000, 0, 0, 0, 3'd0, 16'h0021);
        vecs[20] = mk(8'h00, 0, 2'd1, 16'h0000, 1, 0, 0, 3'd0, 16'h0000);
        // Masking, read/write collision, unused address
        vecs[21] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 1, 0, 3'd0, 16'h0000);
        vecs[22] = mk(8'h40, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd0, 16'h0000);
        vecs[23] = mk(8'h00, 0, 2'd1, 16'h0000, 1, 0, 0, 3'd0, 16'h0040);
        vecs[24] = mk(8'h00, 0, 2'd0, 16'h0040, 0, 1, 0, 3'd0, 16'h0040);
        vecs[25] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd6, 16'h0040);
        vecs[26] = mk(8'h00, 0, 2'd0, 16'h0041, 1, 1, 1, 3'd6, 16'h0040);
        vecs[27] = mk(8'h00, 0, 2'd0, 16'h0000, 1, 0, 1, 3'd6, 16'h0041);
        vecs[28] = mk(8'h00, 0, 2'd3, 16'hFFFF, 1, 1, 1, 3'd6, 16'h0000);
        vecs[29] = mk(8'h00, 1, 2'd0, 16'h0000, 0, 0, 0, 3'd6, 16'h0000);
        vecs[30] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd6, 16'h0000);
        // Collisions: edge vs ack clear, edge vs software clear
        vecs[31] = mk(8'h00, 0, 2'd0, 16'h00FF, 0, 1, 0, 3'd6, 16'h0000);
        vecs[32] = mk(8'h02, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd6, 16'h0000);
        vecs[33] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd1, 16'h0000);
        vecs[34] = mk(8'h02, 1, 2'd0, 16'h0000, 0, 0, 0, 3'd1, 16'h0000);
        vecs[35] = mk(8'h00, 0, 2'd1, 16'h0000, 1, 0, 0, 3'd1, 16'h0002);
        vecs[36] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 1, 3'd1, 16'h0002);
        vecs[37] = mk(8'h02, 0, 2'd1, 16'h0002, 0, 1, 1, 3'd1, 16'h0002);
        vecs[38] = mk(8'h00, 0, 2'd1, 16'h0000, 1, 0, 1, 3'd1, 16'h0002);
        // Software clear of the active source does not revoke the request
        vecs[39] = mk(8'h00, 0, 2'd1, 16'h0002, 0, 1, 1, 3'd1, 16'h0002);
        vecs[40] = mk(8'h00, 0, 2'd1, 16'h0000, 1, 0, 1, 3'd1, 16'h0000);
        vecs[41] = mk(8'h00, 1, 2'd0, 16'h0000, 0, 0, 0, 3'd1, 16'h0000);
        vecs[42] = mk(8'h00, 0, 2'd0, 16'h0000, 0, 0, 0, 3'd1, 16'h0000);

        rst = 1'b1;
        drive(8'h00, 0, 2'd0, 16'h0000, 0, 0);
        #1;
        check("reset_en", {15'h0, interrupt_en}, 16'h0000);
        check("reset_num", {13'h0, interrupt_num}, 16'h0000);
        check("reset_dout", cfg_data_out, 16'h0000);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].irq, vecs[i].ack, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr);
            tick();
            check($sformatf("row%0d_en", i), {15'h0, interrupt_en}, {15'h0, vecs[i].en});
            check($sformatf("row%0d_num", i), {13'h0, interrupt_num}, {13'h0, vecs[i].num});
            check($sformatf("row%0d_dout", i), cfg_data_out, vecs[i].dout);
        end

        // Async reset while a request is active, with a second source still pending.
        drive(8'h90, 0, 2'd0, 16'h0000, 0, 0);
        tick();
        drive(8'h00, 0, 2'd2, 16'h0000, 1, 0);
        tick();
        check("pre_rst_en", {15'h0, interrupt_en}, 16'h0001);
        check("pre_rst_num", {13'h0, interrupt_num}, 16'h0004);
        tick();
        check("pre_rst_status", cfg_data_out, 16'h0011);
        drive(8'h01, 0, 2'd0, 16'h0000, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_en", {15'h0, interrupt_en}, 16'h0000);
        check("async_rst_num", {13'h0, interrupt_num}, 16'h0000);
        check("async_rst_dout", cfg_data_out, 16'h0000);
        tick();
        rst = 1'b0;

        // irq_in[0] is held high across release, so the first edge must see it as new.
        drive(8'h01, 0, 2'd1, 16'h0000, 1, 0);
        tick();
        check("post_rst_pending", cfg_data_out, 16'h0000);
        drive(8'h01, 0, 2'd1, 16'h0000, 1, 0);
        tick();
        check("rel_edge_pending", cfg_data_out, 16'h0001);
        drive(8'h01, 0, 2'd0, 16'h0000, 1, 0);
        tick();
        check("post_rst_mask", cfg_data_out, 16'h0000);
        check("masked_en", {15'h0, interrupt_en}, 16'h0000);
        drive(8'h01, 0, 2'd0, 16'h0001, 0, 1);
        tick();
        check("mask_edge_en", {15'h0, interrupt_en}, 16'h0000);
        drive(8'h01, 0, 2'd0, 16'h0000, 0, 0);
        tick();
        check("post_mask_en", {15'h0, interrupt_en}, 16'h0001);
        check("post_mask_num", {13'h0, interrupt_num}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt source for `control_unit`: it drives `interrupt_en` and `interrupt_num`, and consumes `interrupt_ack`.
- Latches rising edges on 8 peripheral request lines into a pending register.
- Applies a software-writable enable mask and selects the highest-priority request (lowest index).
- Holds that request stable until the CPU's handler-return acknowledge.
- Exposes mask, pending and status through a small memory-mapped config port that the address decoder maps into RAM space.

## Interface
- `MASK_RESET`, default 8'h00: enable-mask value after reset (all sources disabled).
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq_in` in 8: request lines, synchronous to `clk`; a request is a 0→1 transition.
- `interrupt_en` out 1: request to CPU; held high until acknowledged.
- `interrupt_num` out 3: index of the request; CPU vectors to 16'h0100 − num.
- `interrupt_ack` in 1: CPU handler-return acknowledge; high for one or more consecutive cycles per return.
- `cfg_addr` in 2: register select.
- `cfg_data_in` in 16: write data.
- `cfg_read_en` in 1: read strobe.
- `cfg_write_en` in 1: write strobe.
- `cfg_data_out` out 16: registered read data.

## Operation
- Edge detect: `irq_prev` <= `irq_in` each cycle. `set_vec = irq_in & ~irq_prev` ORs into `pending`. Level-high lines do not re-trigger.
- `eligible = pending & mask`. Winner = lowest set bit index.
- FSM states IDLE, REQUEST, ACK_WAIT:
  - IDLE: if `eligible != 0`, latch winner into `interrupt_num`, set `interrupt_en`=1, go to REQUEST. Otherwise stay.
  - REQUEST: `interrupt_en` and `interrupt_num` frozen; mask or pending changes do not alter them. On `interrupt_ack`=1, clear `pending[interrupt_num]`, set `interrupt_en`=0, go to ACK_WAIT.
  - ACK_WAIT: `interrupt_en`=0. When `interrupt_ack`=0, go to IDLE. A multi-cycle ack therefore clears exactly one pending bit.
  - `interrupt_ack` seen in IDLE or ACK_WAIT is ignored; no pending bit is cleared.
- Config registers (only bits listed are meaningful; unlisted read bits return 0):
  - addr 0 MASK (R/W, bits 7:0).
  - addr 1 PENDING: read returns bits 7:0; write-1-to-clear bits 7:0.
  - addr 2 STATUS (RO): bit0 = `interrupt_en`, bit1 = state==ACK_WAIT, bits 4:2 = `interrupt_num`.
  - addr 3: reads 0; writes ignored.
- Read: `cfg_data_out` <= selected register on the edge where `cfg_read_en`=1. Otherwise `cfg_data_out` holds its value.
- Write and read in the same cycle: read returns the pre-write value.
- Software clearing the bit currently being requested does not revoke the request; ack still moves the FSM to ACK_WAIT.
- Simultaneous events on one pending bit, with set winning:
  - edge set + ack clear → bit stays 1.
  - edge set + software clear → bit stays 1.

## Timing
- Reset (async, immediate):
  - `interrupt_en`=0, `interrupt_num`=0, `cfg_data_out`=0.
  - `pending`=0, `irq_prev`=0, `mask`=`MASK_RESET`, FSM=IDLE.
- A line already high at reset release counts as an edge on the first clock.
- Latency, with `irq_in` first sampled high at edge k and the FSM in IDLE:
  - `pending` bit set after edge k.
  - `interrupt_en`/`interrupt_num` valid after edge k+1.
- Ack sampled at edge a: `interrupt_en`=0 after edge a. The earliest next request is asserted after the edge following ack deassertion, so the minimum gap is 1 cycle in IDLE.
- Mask write at edge w, with an eligible source and the FSM in IDLE: `interrupt_en` rises after edge w+1.
- Config read data is valid after the strobe edge (1-cycle latency).
- Reset asserted in REQUEST drops `interrupt_en` immediately and loses all pending requests.

## Test plan
- Basic flow: mask=8'h08; pulse `irq_in[3]` → `interrupt_en`=1, num=3 two cycles later. Hold ack 3 cycles → en falls after the first ack edge, PENDING reads 0, STATUS bit1=1 until ack drops.
- Priority: mask=8'hFF; edges on bits 5 and 2 in the same cycle → num=2. After ack and release, next request num=5 with a 1-cycle IDLE gap.
- Freeze: during a num=5 request, edge on bit 0 → num stays 5 until ack. Then num=0 is served.
- Masking: mask=0, edge on bit 6 → en stays 0, PENDING=16'h0040. Write mask=8'h40 → en=1, num=6 one cycle after the write edge.
- Collisions: edge on bit 1 in the same cycle as ack of num=1 → PENDING bit1 remains 1 and is re-requested. Write PENDING=16'h0002 alongside a new bit-1 edge → bit stays 1.
- Async reset in REQUEST: assert `rst` mid-cycle → en=0, num=0, `cfg_data_out`=0 immediately. After release, MASK reads `MASK_RESET` and PENDING reads 0.
